// File: rtl/axi4l_regs_bank.sv
// AXI4-Lite slave register bank with parametrised register count and width.
// Supports read-only status slices, per-register reset values, byte strobes and per-register write pulses.
module axi4l_regs_bank #(
  parameter int unsigned                         ADDR_WIDTH = 32,
  parameter int unsigned                         DATA_WIDTH = 32,
  parameter int unsigned                         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]                 RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RESET_VALS = '0
) (
  input  logic                                   axi4l_aclk,
  input  logic                                   axi4l_arst,
  input  logic [ADDR_WIDTH-1:0]                  awaddr,
  input  logic                                   awvalid,
  output logic                                   awready,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  input  logic [DATA_WIDTH/8-1:0]                wstrb,
  input  logic                                   wvalid,
  output logic                                   wready,
  output logic [1:0]                             bresp,
  output logic                                   bvalid,
  input  logic                                   bready,
  input  logic [ADDR_WIDTH-1:0]                  araddr,
  input  logic                                   arvalid,
  output logic                                   arready,
  output logic [DATA_WIDTH-1:0]                  rdata,
  output logic [1:0]                             rresp,
  output logic                                   rvalid,
  input  logic                                   rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]         reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]         reg_in,
  output logic [NUM_REGS-1:0]                    reg_wr
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_LSB = (DATA_WIDTH == 64) ? 3 : 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  wstate_t                 r_wstate;
  rstate_t                 r_rstate;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0]   w_cmt_addr;
  logic [DATA_WIDTH-1:0]   w_cmt_data;
  logic [STRB_W-1:0]       w_cmt_strb;
  logic [ADDR_WIDTH-1:0]   w_cmt_idx;
  logic [ADDR_WIDTH-1:0]   w_rd_idx;
  logic                    w_commit;
  logic                    w_cmt_in_range;
  logic                    w_rd_in_range;
  logic [NUM_REGS-1:0]     w_cmt_hit;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  // Commit takes whichever half was latched earlier plus the live half.
  assign w_cmt_addr = (r_wstate == W_ADDR_HELD) ? r_awaddr : awaddr;
  assign w_cmt_data = (r_wstate == W_DATA_HELD) ? r_wdata  : wdata;
  assign w_cmt_strb = (r_wstate == W_DATA_HELD) ? r_wstrb  : wstrb;
  assign w_commit   = ((r_wstate == W_IDLE)      && awvalid && wvalid) ||
                      ((r_wstate == W_ADDR_HELD) && wvalid) ||
                      ((r_wstate == W_DATA_HELD) && awvalid);

  assign w_cmt_idx      = w_cmt_addr >> IDX_LSB;
  assign w_rd_idx       = araddr >> IDX_LSB;
  assign w_cmt_in_range = (w_cmt_idx < ADDR_WIDTH'(NUM_REGS));
  assign w_rd_in_range  = (w_rd_idx  < ADDR_WIDTH'(NUM_REGS));

  always_comb begin
    w_cmt_hit = '0;
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cmt_hit[i] = (w_cmt_idx == ADDR_WIDTH'(i));
      if (w_rd_idx == ADDR_WIDTH'(i)) begin
        w_rd_data = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  // Register storage and one-cycle write pulses.
  always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
    if (axi4l_arst) begin
      reg_wr <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      reg_wr <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && w_cmt_hit[i] && !RO_MASK[i]) begin
          reg_wr[i] <= 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (w_cmt_strb[k]) begin
              r_regs[i][k*8 +: 8] <= w_cmt_data[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Write channel FSM.
  always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
    if (axi4l_arst) begin
      r_wstate <= W_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (awvalid && wvalid) begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= w_cmt_in_range ? RESP_OKAY : RESP_SLVERR;
            r_wstate <= W_RESP;
          end else if (awvalid) begin
            r_awaddr <= awaddr;
            awready  <= 1'b0;
            r_wstate <= W_ADDR_HELD;
          end else if (wvalid) begin
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
            wready   <= 1'b0;
            r_wstate <= W_DATA_HELD;
          end
        end
        W_ADDR_HELD: begin
          if (wvalid) begin
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= w_cmt_in_range ? RESP_OKAY : RESP_SLVERR;
            r_wstate <= W_RESP;
          end
        end
        W_DATA_HELD: begin
          if (awvalid) begin
            awready  <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= w_cmt_in_range ? RESP_OKAY : RESP_SLVERR;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; data sampled on the AR edge so a same-edge write is not visible.
  always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
    if (axi4l_arst) begin
      r_rstate <= R_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else if (r_rstate == R_IDLE) begin
      if (arvalid) begin
        rdata    <= w_rd_in_range ? w_rd_data : '0;
        rresp    <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        rvalid   <= 1'b1;
        arready  <= 1'b0;
        r_rstate <= R_DATA;
      end
    end else begin
      if (rready) begin
        rvalid   <= 1'b0;
        arready  <= 1'b1;
        r_rstate <= R_IDLE;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : r_regs[g];
  end

endmodule

// File: tb/tb_axi4l_regs_bank.sv
// Directed bench for axi4l_regs_bank: 16 x 32-bit registers, register 2 read-only.
module tb_axi4l_regs_bank;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;
  localparam logic [NR-1:0]    RO = 16'h0004;
  localparam logic [NR*DW-1:0] RV = ((NR*DW)'(32'hDEADBEEF) << 96) | (NR*DW)'(32'h0000A5A5);

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NR*DW-1:0]  reg_out;
  logic [NR*DW-1:0]  reg_in;
  logic [NR-1:0]     reg_wr;

  int errors = 0;
  int checks = 0;
  int pulses [NR] = '{default: 0};
  logic [DW-1:0] exp_regs [NR];

  axi4l_regs_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VALS(RV)
  ) dut (
    .axi4l_aclk(clk), .axi4l_arst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .reg_in(reg_in), .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        if (reg_wr[i]) pulses[i]++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s reg_out[%0d]", tag, i), 64'(reg_out[i*DW +: DW]), 64'(exp_regs[i]));
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    check("wr_accept_in_time", 64'(n < 20), 64'(1));
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid_in_time", 64'(n < 20), 64'(1));
    resp = bresp;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("rd_accept_in_time", 64'(n < 20), 64'(1));
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_one_cycle_latency", 64'(rvalid), 64'(1));
    d = rdata;
    resp = rresp;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]    resp;
    logic [DW-1:0] data;
    int            tot;

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    reg_in = '0;
    reg_in[2*DW +: DW] = 32'h00C0FFEE;
    reg_in[1*DW +: DW] = 32'h55555555;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    exp_regs[0] = 32'h0000A5A5;
    exp_regs[3] = 32'hDEADBEEF;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst awready", 64'(awready), 64'(1));
    check("rst wready",  64'(wready),  64'(1));
    check("rst arready", 64'(arready), 64'(1));
    check("rst bvalid",  64'(bvalid),  64'(0));
    check("rst rvalid",  64'(rvalid),  64'(0));
    check("rst bresp",   64'(bresp),   64'(0));
    check("rst rresp",   64'(rresp),   64'(0));
    check("rst rdata",   64'(rdata),   64'(0));
    check("rst reg_wr",  64'(reg_wr),  64'(0));
    check_regs("rst");
    rst = 1'b0;

    axi_read(32'h0C, data, resp);
    check("rd 0x0C data", 64'(data), 64'(32'hDEADBEEF));
    check("rd 0x0C resp", 64'(resp), 64'(0));

    // Full write then byte-strobed write to register 1
    axi_write(32'h04, 32'h12345678, 4'hF, resp);
    check("wr1 bresp", 64'(resp), 64'(0));
    check("wr1 pulses", 64'(pulses[1]), 64'(1));
    axi_write(32'h04, 32'hAAAAAAAA, 4'h2, resp);
    check("wr1b bresp", 64'(resp), 64'(0));
    check("wr1b pulses", 64'(pulses[1]), 64'(2));
    axi_read(32'h04, data, resp);
    check("rd 0x04 data", 64'(data), 64'(32'h1234AA78));
    check("rd 0x04 resp", 64'(resp), 64'(0));
    exp_regs[1] = 32'h1234AA78;

    // AW three cycles ahead of W, then bready held low for five cycles
    @(negedge clk);
    awaddr = 32'h10; awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    check("aw_first awready", 64'(awready), 64'(0));
    check("aw_first wready",  64'(wready),  64'(1));
    repeat (2) @(negedge clk);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    check("aw_first bvalid", 64'(bvalid), 64'(1));
    check("aw_first bresp",  64'(bresp),  64'(0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bstall%0d bvalid", c),  64'(bvalid),  64'(1));
      check($sformatf("bstall%0d awready", c), 64'(awready), 64'(0));
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check("aw_first bvalid drop", 64'(bvalid), 64'(0));
    check("aw_first awready back", 64'(awready), 64'(1));
    exp_regs[4] = 32'hCAFEF00D;

    // W three cycles ahead of AW
    @(negedge clk);
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    check("w_first wready",  64'(wready),  64'(0));
    check("w_first awready", 64'(awready), 64'(1));
    repeat (2) @(negedge clk);
    awaddr = 32'h14; awvalid = 1'b1; bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    check("w_first bvalid", 64'(bvalid), 64'(1));
    check("w_first bresp",  64'(bresp),  64'(0));
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check("w_first bvalid drop", 64'(bvalid), 64'(0));
    exp_regs[5] = 32'h0BADF00D;
    check("pulses reg4", 64'(pulses[4]), 64'(1));
    check("pulses reg5", 64'(pulses[5]), 64'(1));
    axi_read(32'h10, data, resp);
    check("rd 0x10 data", 64'(data), 64'(32'hCAFEF00D));
    axi_read(32'h14, data, resp);
    check("rd 0x14 data", 64'(data), 64'(32'h0BADF00D));

    // Read-only register
    axi_write(32'h08, 32'hFFFFFFFF, 4'hF, resp);
    check("ro bresp", 64'(resp), 64'(0));
    check("ro no pulse", 64'(pulses[2]), 64'(0));
    axi_read(32'h08, data, resp);
    check("ro rd data", 64'(data), 64'(32'h00C0FFEE));
    check("ro rd resp", 64'(resp), 64'(0));

    // Out of range and boundaries
    axi_write(32'h40, 32'h77777777, 4'hF, resp);
    check("oor wr bresp", 64'(resp), 64'(2));
    tot = 0;
    for (int i = 0; i < NR; i++) tot += pulses[i];
    check("oor no pulse total", 64'(tot), 64'(4));
    check_regs("after oor");
    axi_read(32'h40, data, resp);
    check("oor rd data", 64'(data), 64'(0));
    check("oor rd resp", 64'(resp), 64'(2));
    axi_read(32'h80000004, data, resp);
    check("upper bits rd resp", 64'(resp), 64'(2));
    axi_read(32'h3F, data, resp);
    check("last reg rd resp", 64'(resp), 64'(0));
    check("last reg rd data", 64'(data), 64'(0));

    // Zero-strobe write still pulses
    axi_write(32'h18, 32'hFFFFFFFF, 4'h0, resp);
    check("strb0 bresp", 64'(resp), 64'(0));
    check("strb0 pulse", 64'(pulses[6]), 64'(1));
    check("strb0 no change", 64'(reg_out[6*DW +: DW]), 64'(0));

    // Same-edge read and write to register 3, then reset with both responses pending
    @(negedge clk);
    awaddr = 32'h0C; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0C; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("coll bvalid", 64'(bvalid), 64'(1));
    check("coll rvalid", 64'(rvalid), 64'(1));
    check("coll rdata pre-write", 64'(rdata), 64'(32'hDEADBEEF));
    check("coll reg3 written", 64'(reg_out[3*DW +: DW]), 64'(32'h11112222));
    #1 rst = 1'b1;
    #1;
    check("midrst bvalid",  64'(bvalid),  64'(0));
    check("midrst rvalid",  64'(rvalid),  64'(0));
    check("midrst rdata",   64'(rdata),   64'(0));
    check("midrst awready", 64'(awready), 64'(1));
    check("midrst arready", 64'(arready), 64'(1));
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    exp_regs[0] = 32'h0000A5A5;
    exp_regs[3] = 32'hDEADBEEF;
    check_regs("midrst");
    @(negedge clk);
    rst = 1'b0;
    axi_write(32'h04, 32'h0F0F0F0F, 4'hF, resp);
    check("post rst bresp", 64'(resp), 64'(0));
    axi_read(32'h04, data, resp);
    check("post rst rd data", 64'(data), 64'(32'h0F0F0F0F));
    check("post rst rd resp", 64'(resp), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4l_regs_bank.md
Name: axi4l_regs_bank

Overview:
- Parametrised AXI4-Lite slave register bank; the next generation of the fixed-size register slave exercised by the current AXI4-Lite master BFM bench.
- Generalised in register count and data width.
- Adds per-register read-only masking, per-register reset values and byte-strobe writes.
- Adds SLVERR on out-of-range access and a one-cycle write-strobe pulse per register for fabric logic.
- Sits between the AXI4-Lite interconnect and peripheral control/status logic.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; 32 or 64 only
NUM_REGS, 16, number of registers, 1..256
RO_MASK, 0, NUM_REGS-bit vector; bit i=1 makes register i read-only (reads reg_in slice i)
RESET_VALS, 0, NUM_REGS*DATA_WIDTH flat vector of reset values for RW registers

Ports:
axi4l_aclk  in  1  clock
axi4l_arst  in  1  reset, asynchronous, active-high
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read valid
rready  in  1  read ready
reg_out  out  NUM_REGS*DATA_WIDTH  current RW register contents, register i at slice i
reg_in  in  NUM_REGS*DATA_WIDTH  status inputs for RO registers
reg_wr  out  NUM_REGS  one-cycle pulse when register i is written

Behaviour:
- Reset (asynchronous on axi4l_arst high, released synchronously by design convention):
  - awready=1, wready=1, arready=1
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, reg_wr=0
  - RW registers load RESET_VALS; write FSM to W_IDLE, read FSM to R_IDLE.
  - Reset mid-transaction drops any pending response; no partial write is committed.
- Decode: byte offset = address; index = addr >> log2(DATA_WIDTH/8); sub-word low bits ignored. Access is in range iff index < NUM_REGS, with all upper address bits included.
- Write FSM, states W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP:
  - W_IDLE: awready=wready=1. Both handshakes in the same cycle: commit, go to W_RESP. AW only: latch address, deassert awready, go to W_ADDR_HELD. W only: latch data and strobes, deassert wready, go to W_DATA_HELD.
  - W_ADDR_HELD / W_DATA_HELD: wait for the missing channel's handshake, then commit and go to W_RESP.
  - Commit: for an in-range RW register, update byte k iff wstrb[k]. Pulse reg_wr[i] for exactly the cycle after the commit edge, also when wstrb=0. bresp=OKAY.
  - Commit to an RO register: no update, no pulse, bresp=OKAY.
  - Commit out of range: no update, no pulse, bresp=SLVERR (2'b10).
  - W_RESP: bvalid=1 from the cycle after the commit; awready=wready=0. When bvalid&&bready, return to W_IDLE with awready=wready=1 on the next cycle. Maximum throughput is one write per 2 cycles.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On handshake, capture rdata and rresp at that edge, go to R_DATA.
  - rdata source: RW register value, or reg_in slice for RO; out of range gives rdata=0, rresp=SLVERR.
  - R_DATA: rvalid=1, arready=0. rdata/rresp are held stable until rvalid&&rready, then return to R_IDLE.
  - Latency is one cycle from AR handshake to rvalid.
- Simultaneous read and write to the same register: a read whose AR handshake occurs on the commit edge returns the pre-write value. Read and write paths are otherwise independent.
- reg_out reflects register state combinationally from flops; it is 0 for RO slices.

Test Plan:
- Reset: RESET_VALS[3]=0xDEADBEEF; read 0x0C -> rdata=0xDEADBEEF, rresp=0. Outputs at reset match the list above.
- Write 0x04 with data 0x12345678, wstrb=0xF, then write 0x04 with data 0xAAAAAAAA, wstrb=0x2. Read 0x04 -> 0x1234AA78. reg_wr[1] pulses once per write; bresp=0.
- AW presented 3 cycles before W, then the reverse order: both commit, one bvalid each. Holding bready=0 for 5 cycles keeps bvalid=1 and awready=0.
- RO_MASK bit 2 set, reg_in slice 2=0x00C0FFEE: write 0x08 -> bresp=OKAY, no reg_wr[2]; read 0x08 -> 0x00C0FFEE.
- NUM_REGS=16: write 0x40 -> bresp=2'b10, no register changes; read 0x40 -> rdata=0, rresp=2'b10.
- Assert axi4l_arst while bvalid=1 and rvalid=1 -> both drop immediately, registers return to RESET_VALS, next transaction completes normally.
